// File: rtl/instr_decode.sv
// Decode stage: field extraction, register file, load-use stall FSM, 1-cycle latency.
// Optional same-cycle write-back bypass on register reads: define DECODE_WB_BYPASS_EN.
module instr_decode #(
   parameter int NUM_REGS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ir,
   input  logic        ir_valid,
   input  logic        hold_in,
   input  logic        wb_en,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic        stall_out,
   output logic        dec_valid,
   output logic [5:0]  dec_opcode,
   output logic [5:0]  dec_funct,
   output logic [4:0]  dec_shamt,
   output logic [4:0]  dec_dest,
   output logic [31:0] dec_rs_data,
   output logic [31:0] dec_rt_data,
   output logic [31:0] dec_imm
);

   typedef enum logic {RUN, STALL} state_t;

   state_t      state, state_next;
   logic [31:0] regs [NUM_REGS];

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt, dest;
   logic [15:0] imm;
   logic [31:0] imm_ext, rs_data, rt_data;
   logic        hazard, load, bubble, stall_raw;

   assign opcode = ir[31:26];
   assign rs     = ir[25:21];
   assign rt     = ir[20:16];
   assign rd     = ir[15:11];
   assign shamt  = ir[10:6];
   assign funct  = ir[5:0];
   assign imm    = ir[15:0];

   assign dest    = (opcode == 6'h00) ? rd : rt;
   assign imm_ext = (opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E)
                    ? {16'h0000, imm} : {{16{imm[15]}}, imm};

   always_comb begin
      rs_data = '0;
      rt_data = '0;
      if (rs != '0) rs_data = regs[rs];
      if (rt != '0) rt_data = regs[rt];
`ifdef DECODE_WB_BYPASS_EN
      if (wb_en && wb_addr != '0 && wb_addr == rs) rs_data = wb_data;
      if (wb_en && wb_addr != '0 && wb_addr == rt) rt_data = wb_data;
`endif
   end

   // Bubbles never match, so a freshly reset or stalled stage cannot re-stall.
   assign hazard = dec_valid && (dec_opcode == 6'h23) && (dec_dest != '0) && ir_valid
                   && ((dec_dest == rs) || (dec_dest == rt));

   always_comb begin
      state_next = state;
      load       = 1'b0;
      bubble     = 1'b0;
      stall_raw  = 1'b0;
      if (hold_in) begin
         stall_raw = 1'b1;
      end else begin
         case (state)
            RUN: begin
               load = 1'b1;
               if (hazard) begin
                  stall_raw  = 1'b1;
                  bubble     = 1'b1;
                  state_next = STALL;
               end
            end
            STALL: begin
               load       = 1'b1;
               state_next = RUN;
            end
            default: state_next = RUN;
         endcase
      end
   end

   assign stall_out = stall_raw && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= RUN;
      else       state <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dec_valid   <= 1'b0;
         dec_opcode  <= '0;
         dec_funct   <= '0;
         dec_shamt   <= '0;
         dec_dest    <= '0;
         dec_rs_data <= '0;
         dec_rt_data <= '0;
         dec_imm     <= '0;
      end else if (load) begin
         dec_valid   <= ir_valid && !bubble;
         dec_opcode  <= opcode;
         dec_funct   <= funct;
         dec_shamt   <= shamt;
         dec_dest    <= dest;
         dec_rs_data <= rs_data;
         dec_rt_data <= rt_data;
         dec_imm     <= imm_ext;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) regs <= '{default: '0};
      else if (wb_en && wb_addr != '0) regs[wb_addr] <= wb_data;
   end

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode with a scoreboard of predicted decode results.
module tb_instr_decode;

   logic        clk = 1'b0;
   logic        reset, ir_valid, hold_in, wb_en;
   logic [31:0] ir, wb_data;
   logic [4:0]  wb_addr;
   logic        stall_out, dec_valid;
   logic [5:0]  dec_opcode, dec_funct;
   logic [4:0]  dec_shamt, dec_dest;
   logic [31:0] dec_rs_data, dec_rt_data, dec_imm;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic        full;
      logic        valid;
      logic [5:0]  opcode, funct;
      logic [4:0]  shamt, dest;
      logic [31:0] rs_data, rt_data, imm;
   } exp_t;

   exp_t        sb[$];
   exp_t        last_e;
   logic [31:0] model_rf [32];

   instr_decode #(.NUM_REGS(32)) dut (
      .clk(clk), .reset(reset), .ir(ir), .ir_valid(ir_valid), .hold_in(hold_in),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .stall_out(stall_out),
      .dec_valid(dec_valid), .dec_opcode(dec_opcode), .dec_funct(dec_funct),
      .dec_shamt(dec_shamt), .dec_dest(dec_dest), .dec_rs_data(dec_rs_data),
      .dec_rt_data(dec_rt_data), .dec_imm(dec_imm)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic exp_t predict(input logic [31:0] w, input logic v);
      exp_t e;
      logic [5:0] op;
      logic [4:0] a_rs, a_rt;
      op   = w[31:26];
      a_rs = w[25:21];
      a_rt = w[20:16];
      e.full   = v;
      e.valid  = v;
      e.opcode = op;
      e.funct  = w[5:0];
      e.shamt  = w[10:6];
      e.dest   = (op == 6'h00) ? w[15:11] : w[20:16];
      e.imm    = (op == 6'h0C || op == 6'h0D || op == 6'h0E)
                 ? {16'h0000, w[15:0]} : {{16{w[15]}}, w[15:0]};
      e.rs_data = (a_rs == 5'd0) ? 32'h0 : model_rf[a_rs];
      e.rt_data = (a_rt == 5'd0) ? 32'h0 : model_rf[a_rt];
`ifdef DECODE_WB_BYPASS_EN
      if (wb_en && wb_addr != 5'd0 && wb_addr == a_rs) e.rs_data = wb_data;
      if (wb_en && wb_addr != 5'd0 && wb_addr == a_rt) e.rt_data = wb_data;
`endif
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] w, input logic v);
      ir       = w;
      ir_valid = v;
      sb.push_back(predict(w, v));
   endtask

   task automatic push_bubble();
      exp_t e;
      e = predict(32'h0, 1'b0);
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      if (wb_en && wb_addr != 5'd0) model_rf[wb_addr] = wb_data;
      #1;
      wb_en = 1'b0;
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL %s: scoreboard empty, observed valid %b expected an entry", tag, dec_valid);
      end else begin
         e = sb.pop_front();
         last_e = e;
         chk({tag, ".valid"}, {31'b0, dec_valid}, {31'b0, e.valid});
         if (e.full) begin
            chk({tag, ".opcode"}, {26'b0, dec_opcode}, {26'b0, e.opcode});
            chk({tag, ".funct"},  {26'b0, dec_funct},  {26'b0, e.funct});
            chk({tag, ".shamt"},  {27'b0, dec_shamt},  {27'b0, e.shamt});
            chk({tag, ".dest"},   {27'b0, dec_dest},   {27'b0, e.dest});
            chk({tag, ".rs"},     dec_rs_data, e.rs_data);
            chk({tag, ".rt"},     dec_rt_data, e.rt_data);
            chk({tag, ".imm"},    dec_imm,     e.imm);
         end
      end
   endtask

   initial begin
      logic [4:0] a;
      for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
      reset = 1'b1; hold_in = 1'b1; ir = 32'h0; ir_valid = 1'b0;
      wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.stall", {31'b0, stall_out}, 32'h0);
      chk("rst.valid", {31'b0, dec_valid}, 32'h0);
      chk("rst.dest",  {27'b0, dec_dest},  32'h0);
      chk("rst.rs",    dec_rs_data, 32'h0);
      chk("rst.imm",   dec_imm,     32'h0);
      reset = 1'b0; hold_in = 1'b0;

      // Write R5 then sign-extended addi reading it
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
      drive(32'h0, 1'b0); tick(); check_out("wr_r5");
      drive(32'h20A6FFFF, 1'b1); tick(); check_out("addi");
      chk("addi.imm_k",  dec_imm, 32'hFFFFFFFF);
      chk("addi.rs_k",   dec_rs_data, 32'h1234);
      drive(32'h34A7FFFF, 1'b1); tick(); check_out("ori");
      chk("ori.imm_k",   dec_imm, 32'h0000FFFF);

      // Load-use: one stall cycle, one bubble, then the add
      drive(32'h8C080000, 1'b1); tick(); check_out("lw8");
      ir = 32'h01094020; ir_valid = 1'b1; #1;
      chk("lu.stall", {31'b0, stall_out}, 32'h1);
      push_bubble(); tick(); check_out("lu.bubble");
      chk("lu.release", {31'b0, stall_out}, 32'h0);
      sb.push_back(predict(32'h01094020, 1'b1)); tick(); check_out("lu.add");
      chk("lu.dest_k", {27'b0, dec_dest}, 32'd8);
      drive(32'h0, 1'b0); #1;
      chk("lu.once", {31'b0, stall_out}, 32'h0);
      tick(); check_out("lu.idle");

      // Hold with a pending hazard and writes to R0
      drive(32'h8C0A0000, 1'b1); tick(); check_out("lw10");
      ir = 32'h014A5820; ir_valid = 1'b1; hold_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
         #1;
         chk("hold.stall", {31'b0, stall_out}, 32'h1);
         sb.push_back(last_e); tick(); check_out("hold");
      end
      hold_in = 1'b0; #1;
      chk("hold.hazard", {31'b0, stall_out}, 32'h1);
      push_bubble(); tick(); check_out("hold.bubble");
      sb.push_back(predict(32'h014A5820, 1'b1)); tick(); check_out("hold.add");

      // Same-cycle write-back vs. read of R9
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h1111;
      drive(32'h0, 1'b0); tick(); check_out("wr_r9");
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hCAFE;
      drive(32'h21210000, 1'b1); tick(); check_out("bypass");
`ifdef DECODE_WB_BYPASS_EN
      chk("bypass.k", dec_rs_data, 32'hCAFE);
`else
      chk("bypass.k", dec_rs_data, 32'h1111);
`endif
      drive(32'h21210000, 1'b1); tick(); check_out("after_wb");
      chk("after_wb.k", dec_rs_data, 32'hCAFE);

      drive(32'h20010005, 1'b1); tick(); check_out("r0");
      chk("r0.k", dec_rs_data, 32'h0);

      // Reset asserted in the middle of a stall
      drive(32'h8C0C0000, 1'b1); tick(); check_out("lw12");
      ir = 32'h018C0020; ir_valid = 1'b1; #1;
      chk("mid.stall", {31'b0, stall_out}, 32'h1);
      push_bubble(); tick(); check_out("mid.bubble");
      #2; reset = 1'b1; #1;
      chk("mid.rst_valid", {31'b0, dec_valid}, 32'h0);
      chk("mid.rst_op",    {26'b0, dec_opcode}, 32'h0);
      chk("mid.rst_dest",  {27'b0, dec_dest}, 32'h0);
      chk("mid.rst_rs",    dec_rs_data, 32'h0);
      chk("mid.rst_imm",   dec_imm, 32'h0);
      chk("mid.rst_stall", {31'b0, stall_out}, 32'h0);
      for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
      @(posedge clk); #1;
      reset = 1'b0; #1;
      chk("post.nostall", {31'b0, stall_out}, 32'h0);
      sb.push_back(predict(32'h018C0020, 1'b1)); tick(); check_out("post.dec");

      for (int i = 1; i < 32; i++) begin
         a = 5'(i);
         drive({6'h00, a, a, 16'h0020}, 1'b1); tick(); check_out("clr");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, meaning register-file depth; indexed by 5-bit fields.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ir  input  32  instruction word from the fetch stage.
REQ-005 SHALL have port ir_valid  input  1  ir holds a real instruction this cycle.
REQ-006 SHALL have port hold_in  input  1  downstream stage cannot accept; freeze outputs.
REQ-007 SHALL have ports wb_en (input, 1), wb_addr (input, 5) and wb_data (input, 32), forming the write-back request.
REQ-008 SHALL have port stall_out  output  1  fetch must hold pc and ir this cycle; combinational.
REQ-009 SHALL have registered outputs: dec_valid (1), dec_opcode (6), dec_funct (6), dec_shamt (5), dec_dest (5), dec_rs_data (32), dec_rt_data (32) and dec_imm (32).

Function
REQ-010 SHALL decode fields as opcode=ir[31:26], rs=ir[25:21], rt=ir[20:16], rd=ir[15:11], shamt=ir[10:6], funct=ir[5:0] and imm=ir[15:0].
REQ-011 SHALL select dec_dest=rd when opcode==0 (R-type) and dec_dest=rt otherwise.
REQ-012 SHALL zero-extend imm for opcodes 0x0C, 0x0D and 0x0E, and sign-extend it for all other opcodes.
REQ-013 SHALL hold a NUM_REGS x 32 register file and write wb_data at posedge when wb_en=1 and wb_addr!=0.
REQ-014 SHALL read register 0 as 0 always and ignore writes to it.
REQ-015 SHALL have a latency of 1 cycle: ir/ir_valid sampled at edge N SHALL appear on the dec_* outputs after edge N.
REQ-016 SHALL load dec_valid=0 (bubble), with the other dec_* outputs don't-care, when ir_valid=0 and hold_in=0.
REQ-017 SHALL implement a two-state FSM with states RUN and STALL.
REQ-018 SHALL detect a load-use hazard when dec_valid=1, dec_opcode==0x23, dec_dest!=0, ir_valid=1 and dec_dest equals rs or rt of ir.
REQ-019 SHALL, in RUN with a load-use hazard and hold_in=0, assert stall_out, load a bubble, and go to STALL.
REQ-020 SHALL, in STALL with hold_in=0, decode the held ir normally, deassert stall_out, and return to RUN.
REQ-021 SHALL, while hold_in=1, keep all dec_* outputs and FSM state unchanged and assert stall_out; register-file writes still occur.
REQ-022 SHALL give hold_in priority when hold_in and a hazard occur in the same cycle; the hazard is re-evaluated on the next cycle.
REQ-023 SHALL never raise a hazard on a bubble (dec_valid=0).

Reset
REQ-024 SHALL, on reset, immediately clear all dec_* outputs to 0, clear every register-file entry to 0, and force the FSM to RUN.
REQ-025 SHALL keep stall_out at 0 during reset.
REQ-026 SHALL, on reset asserted mid-STALL, abandon the stall; the first post-reset cycle is RUN with dec_valid=0.

Configuration
REQ-027 SHALL, with macro DECODE_WB_BYPASS_EN defined, return wb_data on the rs/rt read when wb_en=1, wb_addr!=0 and wb_addr matches that read address in the same cycle.
REQ-028 SHALL, without DECODE_WB_BYPASS_EN, return the pre-write register contents for such a read; the new value is visible from the next cycle.

Verification
REQ-029 SHALL cover reset: assert reset mid-run -> all dec_* outputs=0, stall_out=0, R1..R31 read 0 afterwards.
REQ-030 SHALL cover write/read and sign extension: write R5=0x1234, then ir=0x20A6FFFF (addi rt=6, rs=5) -> dec_rs_data=0x1234, dec_imm=0xFFFFFFFF, dec_dest=6, dec_valid=1 one cycle later.
REQ-031 SHALL cover zero extension: ir=0x34A7FFFF (ori) -> dec_imm=0x0000FFFF and dec_dest=7.
REQ-032 SHALL cover load-use: ir=0x8C080000 (lw R8), then ir=0x01094020 (add using R8) -> stall_out=1 for exactly one cycle, one bubble, then the add decodes with dec_dest=8.
REQ-033 SHALL cover bypass: wb_en=1, wb_addr=9, wb_data=0xCAFE while ir reads rs=9 -> dec_rs_data=0xCAFE with DECODE_WB_BYPASS_EN, and the old value without it.
REQ-034 SHALL cover hold and register 0: hold_in=1 for 3 cycles -> dec_* outputs stable and stall_out=1; a write to R0 -> R0 still reads 0.
